// File: rtl/pipe_demux_fifo.sv
`timescale 1ns / 1ps
// pipe_demux_fifo: pipe-to-method demultiplexer with one FIFO per channel.
// Each input word is {header, payload}. The header picks a method channel. Words with an
// unknown ID (header >= NUM_CH) are discarded, and a saturating counter records them.
// Ports:
//   CLK, nRST        clock; synchronous active-low reset
//   pipe_enq_ena_i   upstream enqueue strobe
//   pipe_enq_v_i     {method ID, payload}
//   pipe_enq_rdy_o   block can take a word this cycle
//   out_enq_ena_o    per-channel delivery strobe
//   out_enq_v_o      per-channel payload, channel k at [k*PAYLOAD_W +: PAYLOAD_W]
//   out_enq_rdy_i    per-channel downstream ready
//   drop_count_o     saturating count of words dropped for an unknown ID
module pipe_demux_fifo #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned HDR_W     = 16,
  parameter int unsigned PAYLOAD_W = 128,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          pipe_enq_ena_i,
  input  logic [HDR_W+PAYLOAD_W-1:0]    pipe_enq_v_i,
  output logic                          pipe_enq_rdy_o,
  output logic [NUM_CH-1:0]             out_enq_ena_o,
  output logic [NUM_CH*PAYLOAD_W-1:0]   out_enq_v_o,
  input  logic [NUM_CH-1:0]             out_enq_rdy_i,
  output logic [31:0]                   drop_count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [HDR_W-1:0] NumChHdr = HDR_W'(NUM_CH);
  localparam logic [CntW-1:0]  DepthCnt = CntW'(DEPTH);

  // Staging register
  logic                 stg_valid_q, stg_valid_d;
  logic [HDR_W-1:0]     stg_id_q, stg_id_d;
  logic [PAYLOAD_W-1:0] stg_payload_q, stg_payload_d;

  // Per-channel FIFO state
  logic [PAYLOAD_W-1:0] mem_q   [NUM_CH][DEPTH];
  logic [PtrW-1:0]      wr_ptr_q[NUM_CH];
  logic [PtrW-1:0]      rd_ptr_q[NUM_CH];
  logic [CntW-1:0]      cnt_q   [NUM_CH];

  logic [31:0] drop_q, drop_d;

  logic [NUM_CH-1:0] full, empty, push, pop;
  logic              id_ok, sel_full, stg_drain, accept;

  // Full/empty come from registered counts only, so a pop never frees space for a
  // push in the same cycle.
  always_comb begin
    full     = '0;
    empty    = '0;
    sel_full = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      full[k]  = (cnt_q[k] == DepthCnt);
      empty[k] = (cnt_q[k] == '0);
      if (stg_id_q == HDR_W'(k)) sel_full = full[k];
    end
  end

  always_comb begin
    id_ok          = (stg_id_q < NumChHdr);
    stg_drain      = stg_valid_q && (!id_ok || !sel_full);
    pipe_enq_rdy_o = nRST && (!stg_valid_q || stg_drain);
    accept         = pipe_enq_ena_i && pipe_enq_rdy_o;

    push          = '0;
    pop           = '0;
    out_enq_ena_o = '0;
    out_enq_v_o   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      push[k]          = nRST && stg_drain && id_ok && (stg_id_q == HDR_W'(k));
      pop[k]           = nRST && !empty[k] && out_enq_rdy_i[k];
      out_enq_ena_o[k] = pop[k];
      out_enq_v_o[k*PAYLOAD_W +: PAYLOAD_W] = mem_q[k][rd_ptr_q[k]];
    end
  end

  always_comb begin
    stg_valid_d   = stg_valid_q;
    stg_id_d      = stg_id_q;
    stg_payload_d = stg_payload_q;
    if (accept) begin
      stg_valid_d   = 1'b1;
      stg_id_d      = pipe_enq_v_i[HDR_W+PAYLOAD_W-1:PAYLOAD_W];
      stg_payload_d = pipe_enq_v_i[PAYLOAD_W-1:0];
    end else if (stg_drain) begin
      stg_valid_d   = 1'b0;
    end

    drop_d = drop_q;
    if (stg_drain && !id_ok && (drop_q != '1)) drop_d = drop_q + 32'd1;
  end

  assign drop_count_o = drop_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stg_valid_q   <= 1'b0;
      stg_id_q      <= '0;
      stg_payload_q <= '0;
      drop_q        <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
    end else begin
      stg_valid_q   <= stg_valid_d;
      stg_id_q      <= stg_id_d;
      stg_payload_q <= stg_payload_d;
      drop_q        <= drop_d;
      for (int k = 0; k < NUM_CH; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PtrW'(1);
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PtrW'(1);
        unique case ({push[k], pop[k]})
          2'b10:   cnt_q[k] <= cnt_q[k] + CntW'(1);
          2'b01:   cnt_q[k] <= cnt_q[k] - CntW'(1);
          default: cnt_q[k] <= cnt_q[k];
        endcase
      end
    end
  end

  // Storage needs no reset: pointers and counts define what is valid.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= stg_payload_q;
    end
  end

endmodule

// File: tb/tb_pipe_demux_fifo.sv
`timescale 1ns / 1ps
// Randomised and directed bench for pipe_demux_fifo. A reference model keeps one
// expected-payload queue per channel plus an expected drop count, and a monitor
// checks every delivery against those queues.
module tb_pipe_demux_fifo;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned HDR_W  = 16;
  localparam int unsigned PW     = 128;
  localparam int unsigned DEPTH  = 4;

  logic                   clk = 1'b0;
  logic                   nrst = 1'b0;
  logic                   enq_ena = 1'b0;
  logic [HDR_W+PW-1:0]    enq_v = '0;
  logic                   enq_rdy;
  logic [NUM_CH-1:0]      out_ena;
  logic [NUM_CH*PW-1:0]   out_v;
  logic [NUM_CH-1:0]      out_rdy = '1;
  logic [31:0]            drop_cnt;

  int compared = 0;
  int mismatched = 0;
  logic [PW-1:0] exp_q[NUM_CH][$];
  logic [31:0]   exp_drop = 0;
  bit            rnd_on = 1'b0;

  always #5 clk = ~clk;

  pipe_demux_fifo #(
    .NUM_CH   (NUM_CH),
    .HDR_W    (HDR_W),
    .PAYLOAD_W(PW),
    .DEPTH    (DEPTH)
  ) dut (
    .CLK           (clk),
    .nRST          (nrst),
    .pipe_enq_ena_i(enq_ena),
    .pipe_enq_v_i  (enq_v),
    .pipe_enq_rdy_o(enq_rdy),
    .out_enq_ena_o (out_ena),
    .out_enq_v_o   (out_v),
    .out_enq_rdy_i (out_rdy),
    .drop_count_o  (drop_cnt)
  );

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: an accepted word goes to its channel queue, or counts as a drop.
  task automatic model_accept(input logic [HDR_W-1:0] id, input logic [PW-1:0] pl);
    if (32'(id) < NUM_CH) exp_q[id].push_back(pl);
    else if (exp_drop != 32'hFFFF_FFFF) exp_drop++;
  endtask

  // Offer a word from the next falling edge until accepted; returns after the accepting edge.
  task automatic send(input logic [HDR_W-1:0] id, input logic [PW-1:0] pl, output int stalls);
    bit done;
    done = 1'b0;
    stalls = 0;
    @(negedge clk);
    enq_ena = 1'b1;
    enq_v   = {id, pl};
    for (int i = 0; i < 200 && !done; i++) begin
      #1;
      if (enq_rdy) begin
        model_accept(id, pl);
        done = 1'b1;
        @(posedge clk);
      end else begin
        stalls++;
        @(negedge clk);
      end
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got no accept in 200 cycles required accept (id %0h)", id);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    enq_ena = 1'b0;
    #2;
  endtask

  // Monitor: every delivery must match the head of that channel's expected queue.
  initial begin
    logic [PW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < NUM_CH; k++) begin
        if (out_ena[k]) begin
          compared++;
          if (exp_q[k].size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_delivery ch%0d: got %0h required none", k,
                     out_v[k*PW +: PW]);
          end else begin
            e = exp_q[k].pop_front();
            if (out_v[k*PW +: PW] !== e) begin
              mismatched++;
              $display("FAIL delivery_ch%0d: got %0h required %0h", k, out_v[k*PW +: PW], e);
            end
          end
        end
      end
    end
  end

  // Random downstream back-pressure during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (rnd_on) out_rdy = NUM_CH'($urandom);
    end
  end

  initial begin
    int st, tot;
    logic [HDR_W-1:0] id;
    logic [PW-1:0] pl;
    int r;

    // Reset then idle
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    #2;
    chk("reset_rdy", PW'(enq_rdy), PW'(1));
    chk("reset_ena", PW'(out_ena), PW'(0));
    chk("reset_drop", PW'(drop_cnt), PW'(0));

    // Single word to ch2: delivered exactly 2 cycles after accept, for one cycle
    send(16'd2, 128'hA5, st);
    tick();
    chk("lat_cyc1_ena", PW'(out_ena), PW'(0));
    tick();
    chk("lat_cyc2_ena", PW'(out_ena), PW'(4'b0100));
    chk("lat_cyc2_data", out_v[2*PW +: PW], 128'hA5);
    tick();
    chk("lat_cyc3_ena", PW'(out_ena), PW'(0));

    // ch1 back-pressured: 4 buffered, 5th staged, 6th held upstream
    out_rdy[1] = 1'b0;
    tot = 0;
    for (int i = 1; i <= 5; i++) begin
      send(16'd1, PW'(i), st);
      tot += st;
    end
    chk("ch1_fill_stalls", PW'(tot), PW'(0));
    @(negedge clk);
    enq_ena = 1'b1;
    enq_v   = {16'd1, 128'd6};
    #1;
    chk("ch1_full_rdy", PW'(enq_rdy), PW'(0));
    repeat (2) @(negedge clk);
    #1;
    chk("ch1_full_rdy_hold", PW'(enq_rdy), PW'(0));
    out_rdy[1] = 1'b1;
    send(16'd1, 128'd6, st);
    repeat (10) tick();
    chk("ch1_drained", PW'(exp_q[1].size()), PW'(0));
    chk("ch1_rdy_back", PW'(enq_rdy), PW'(1));

    // Unknown IDs dropped without stalling
    tot = 0;
    send(16'd7, 128'h70, st);     tot += st;
    send(16'h8000, 128'h80, st);  tot += st;
    send(16'd0, 128'hC0FFEE, st); tot += st;
    repeat (4) tick();
    chk("drop_stalls", PW'(tot), PW'(0));
    chk("drop_count", PW'(drop_cnt), PW'(exp_drop));
    chk("drop_count_two", PW'(exp_drop), PW'(2));
    chk("drop_ch0_drained", PW'(exp_q[0].size()), PW'(0));

    // Full ch0 with a staged ch0 word: the pop does not free space in the same cycle
    out_rdy[0] = 1'b0;
    for (int i = 0; i < 5; i++) send(16'd0, PW'(32'h100 + i), st);
    repeat (2) tick();
    chk("ch0_full_rdy", PW'(enq_rdy), PW'(0));
    @(negedge clk);
    out_rdy[0] = 1'b1;
    #2;
    chk("ch0_pop_ena", PW'(out_ena[0]), PW'(1));
    chk("ch0_no_bypass", PW'(enq_rdy), PW'(0));
    tick();
    chk("ch0_push_next", PW'(enq_rdy), PW'(1));
    repeat (8) tick();
    chk("ch0_drained", PW'(exp_q[0].size()), PW'(0));

    // Mid-stream reset with buffered words
    out_rdy[2] = 1'b0;
    for (int i = 0; i < 3; i++) send(16'd2, PW'(32'h200 + i), st);
    repeat (2) tick();
    @(negedge clk);
    nrst = 1'b0;
    out_rdy = '1;
    for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
    exp_drop = 0;
    #2;
    chk("rst_rdy_low", PW'(enq_rdy), PW'(0));
    chk("rst_ena_low", PW'(out_ena), PW'(0));
    @(negedge clk);
    nrst = 1'b1;
    #2;
    chk("post_rst_ena", PW'(out_ena), PW'(0));
    chk("post_rst_drop", PW'(drop_cnt), PW'(0));
    chk("post_rst_rdy", PW'(enq_rdy), PW'(1));
    repeat (5) tick();

    // Random traffic against the model
    rnd_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)       id = HDR_W'(r % NUM_CH);
      else if (r == 6) id = 16'h8000;
      else if (r == 7) id = 16'hFFFF;
      else             id = HDR_W'(NUM_CH + r);
      pl = {$urandom, $urandom, $urandom, $urandom};
      send(id, pl, st);
      if ($urandom_range(0, 3) == 0) tick();
    end
    tick();
    rnd_on = 1'b0;
    @(negedge clk);
    out_rdy = '1;
    repeat (20) tick();
    for (int k = 0; k < NUM_CH; k++) chk($sformatf("rnd_drain_ch%0d", k), PW'(exp_q[k].size()),
                                         PW'(0));
    chk("rnd_drop_count", PW'(drop_cnt), PW'(exp_drop));
    chk("rnd_rdy_idle", PW'(enq_rdy), PW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
